// File: rtl/lc_isa_pkg.sv
// Shared ISA definitions for the 16-bit teaching processor: opcodes,
// instruction field positions, sequencer FSM states and datapath width.
package lc_isa_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SLR = 3'b111;

    // Instruction word layout: [8:6]=III, [5:3]=XXX, [2:0]=YYY
    localparam int IR_W    = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 6;
    localparam int X_HI    = 5;
    localparam int X_LO    = 3;
    localparam int Y_HI    = 2;
    localparam int Y_LO    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IMM  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // Opcodes whose result comes from the external ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op != OP_MV) && (op != OP_MVI);
    endfunction

endpackage

// File: rtl/register_bank.sv
// Register file: one synchronous write port, two combinational read ports
// and a debug read port; synchronous clear on reset.
module register_bank
    import lc_isa_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_x,
    input  logic [AW-1:0]    i_raddr_y,
    input  logic [AW-1:0]    i_dbg_sel,
    output logic [WIDTH-1:0] o_rdata_x,
    output logic [WIDTH-1:0] o_rdata_y,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_regs [NREGS];

    // Reset has priority so a write requested in the reset cycle never commits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_x  = r_regs[i_raddr_x];
        o_rdata_y  = r_regs[i_raddr_y];
        o_dbg_data = r_regs[i_dbg_sel];
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: accepts IIIXXXYYY words (plus an
// immediate for mvi), drives the external ALU and writes results back to rX.
module alu_sequencer
    import lc_isa_pkg::*;
#(
    parameter int NREGS = lc_isa_pkg::NREGS,
    parameter int WIDTH = lc_isa_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [15:0]      din,
    output logic             instr_ready,
    output logic             done,
    output logic             overflow,
    output logic [2:0]       alu_op_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_wrap,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    // Handshake: a word on din is consumed at a rising edge where run and
    // instr_ready are both high; run in any other state is simply ignored.

    seq_state_e        r_state;
    seq_state_e        w_next_state;
    logic [IR_W-1:0]   r_ir;
    logic              r_overflow;

    logic [2:0]        w_op;
    logic [2:0]        w_x;
    logic [2:0]        w_y;
    logic              w_accept;
    logic              w_we;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_ovf_we;
    logic [WIDTH-1:0]  w_rdata_x;
    logic [WIDTH-1:0]  w_rdata_y;

    assign w_op     = r_ir[OP_HI:OP_LO];
    assign w_x      = r_ir[X_HI:X_LO];
    assign w_y      = r_ir[Y_HI:Y_LO];
    assign w_accept = run & instr_ready;
    assign overflow = r_overflow;

    register_bank #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (3)
    ) u_rb (
        .clock      (clock),
        .reset      (reset),
        .i_we       (w_we),
        .i_waddr    (w_x),
        .i_wdata    (w_wdata),
        .i_raddr_x  (w_x),
        .i_raddr_y  (w_y),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_x  (w_rdata_x),
        .o_rdata_y  (w_rdata_y),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_accept) begin
                r_ir <= din[IR_W-1:0];
            end
            if (w_ovf_we) begin
                r_overflow <= alu_wrap;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        instr_ready  = 1'b0;
        done         = 1'b0;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_ovf_we     = 1'b0;
        alu_op_code  = OP_MV;
        alu_a        = '0;
        alu_b        = '0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = (din[OP_HI:OP_LO] == OP_MVI) ? ST_IMM : ST_EXEC;
                end
            end
            ST_IMM: begin
                instr_ready = 1'b1;
                if (w_accept) begin
                    w_we         = 1'b1;
                    w_wdata      = din;
                    w_next_state = ST_DONE;
                end
            end
            ST_EXEC: begin
                // Operands are read combinationally before the write edge, so X==Y is safe.
                if (w_op == OP_MV) begin
                    w_we    = 1'b1;
                    w_wdata = w_rdata_y;
                end else if (is_alu_op(w_op)) begin
                    alu_op_code = w_op;
                    alu_a       = w_rdata_y;
                    alu_b       = w_rdata_x;
                    w_we        = 1'b1;
                    w_wdata     = alu_s;
                    w_ovf_we    = (w_op == OP_ADD) || (w_op == OP_SUB);
                end
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached and a
// reference register model feeding an expected-result queue.
module tb_alu_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        instr_ready;
    logic        done;
    logic        overflow;
    logic [2:0]  alu_op_code;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_s;
    logic        alu_wrap;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    logic [15:0] exp_q[$];
    logic [15:0] m_rb [8];
    logic        m_ovf;
    int          n_checks;
    int          n_fail;

    alu_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .din         (din),
        .instr_ready (instr_ready),
        .done        (done),
        .overflow    (overflow),
        .alu_op_code (alu_op_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_wrap    (alu_wrap),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational ALU: a and b as seen by the ALU, b is the rX side.
    always_comb begin
        alu_s    = 16'h0000;
        alu_wrap = 1'b0;
        case (alu_op_code)
            3'b010: begin
                alu_s    = alu_a + alu_b;
                alu_wrap = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
            end
            3'b011: begin
                alu_s    = alu_b - alu_a;
                alu_wrap = (alu_b[15] != alu_a[15]) && (alu_s[15] != alu_b[15]);
            end
            3'b100:  alu_s = alu_a | alu_b;
            3'b101:  alu_s = (alu_a > alu_b) ? 16'h0001 : 16'h0000;
            3'b110:  alu_s = (alu_a >= 16) ? 16'h0000 : (alu_b << alu_a[3:0]);
            3'b111:  alu_s = (alu_a >= 16) ? 16'h0000 : (alu_b >> alu_a[3:0]);
            default: alu_s = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        @(posedge clock);
        #1;
        din = w;
        run = 1'b1;
        @(negedge clock);
        while (!instr_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
        @(posedge clock);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        @(negedge clock);
        while (!done && n < 8) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic score_result(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            check(tag, 32'(dbg_data), 32'(exp_q.pop_front()));
        end
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_mvi(input logic [2:0] x, input logic [15:0] val, input int gap);
        int n;
        dbg_sel = x;
        send_word({7'b0, 3'b001, x, 3'b000});
        for (int i = 0; i < gap; i++) begin
            @(negedge clock);
            check("imm_wait_ready", 32'(instr_ready), 32'd1);
            check("imm_wait_done", 32'(done), 32'd0);
        end
        m_rb[x] = val;
        exp_q.push_back(val);
        send_word(val);
        wait_done(n);
        check("mvi_done_lat", 32'(n), 32'd1);
        score_result("mvi_result");
        @(negedge clock);
        check("mvi_done_pulse", 32'(done), 32'd0);
    endtask

    task automatic exec_instr(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                              input bit extra_run);
        logic [15:0] rx, ry, res;
        logic        nov;
        int          n;
        rx  = m_rb[x];
        ry  = m_rb[y];
        nov = m_ovf;
        case (op)
            3'b000: res = ry;
            3'b010: begin
                res = rx + ry;
                nov = (rx[15] == ry[15]) && (res[15] != rx[15]);
            end
            3'b011: begin
                res = rx - ry;
                nov = (rx[15] != ry[15]) && (res[15] != rx[15]);
            end
            3'b100:  res = rx | ry;
            3'b101:  res = (rx < ry) ? 16'h0001 : 16'h0000;
            3'b110:  res = (ry >= 16) ? 16'h0000 : (rx << ry[3:0]);
            3'b111:  res = (ry >= 16) ? 16'h0000 : (rx >> ry[3:0]);
            default: res = rx;
        endcase
        m_rb[x] = res;
        m_ovf   = nov;
        exp_q.push_back(res);
        dbg_sel = x;
        send_word({7'b0, op, x, y});
        if (extra_run) begin
            run = 1'b1;
            din = 16'h0048;
        end
        @(negedge clock);
        check("exec_opcode", 32'(alu_op_code), (op >= 3'b010) ? 32'(op) : 32'd0);
        check("exec_a", 32'(alu_a), (op >= 3'b010) ? 32'(ry) : 32'd0);
        check("exec_b", 32'(alu_b), (op >= 3'b010) ? 32'(rx) : 32'd0);
        check("exec_ready", 32'(instr_ready), 32'd0);
        n = 1;
        while (!done && n < 8) begin
            @(negedge clock);
            n++;
        end
        check("exec_done_lat", 32'(n), 32'd2);
        check("done_opcode", 32'(alu_op_code), 32'd0);
        score_result("exec_result");
        if (extra_run) begin
            @(posedge clock);
            #1;
            run = 1'b0;
        end
        @(negedge clock);
        check("exec_done_pulse", 32'(done), 32'd0);
        check("back_to_idle", 32'(instr_ready), 32'd1);
        if (extra_run) begin
            @(negedge clock);
            check("ignored_run_idle", 32'(instr_ready), 32'd1);
            check("ignored_run_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  op, x, y;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        run      = 1'b0;
        din      = 16'h0000;
        dbg_sel  = 3'd0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 8; i++) m_rb[i] = 16'h0000;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_op", 32'(alu_op_code), 32'd0);
        check("rst_a", 32'(alu_a), 32'd0);
        check("rst_b", 32'(alu_b), 32'd0);
        check("rst_dbg", 32'(dbg_data), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);

        do_mvi(3'd1, 16'h0005, 0);

        do_mvi(3'd1, 16'h7FFF, 2);
        do_mvi(3'd2, 16'h0001, 0);
        exec_instr(3'b010, 3'd1, 3'd2, 1'b0);

        do_mvi(3'd3, 16'd2, 0);
        do_mvi(3'd4, 16'd9, 0);
        exec_instr(3'b101, 3'd3, 3'd4, 1'b0);
        do_mvi(3'd3, 16'd9, 0);
        do_mvi(3'd4, 16'd2, 1);
        exec_instr(3'b101, 3'd3, 3'd4, 1'b0);

        do_mvi(3'd5, 16'h0003, 0);
        do_mvi(3'd6, 16'd4, 0);
        exec_instr(3'b110, 3'd5, 3'd6, 1'b0);
        exec_instr(3'b111, 3'd5, 3'd6, 1'b0);

        exec_instr(3'b000, 3'd7, 3'd1, 1'b1);
        dbg_sel = 3'd1;
        #1;
        check("r1_after_ignored_run", 32'(dbg_data), 32'(m_rb[1]));

        exec_instr(3'b010, 3'd1, 3'd1, 1'b0);
        exec_instr(3'b011, 3'd2, 3'd2, 1'b0);
        do_mvi(3'd0, 16'h8000, 0);
        do_mvi(3'd2, 16'h0001, 0);
        exec_instr(3'b011, 3'd0, 3'd2, 1'b0);
        do_mvi(3'd6, 16'd20, 0);
        exec_instr(3'b110, 3'd5, 3'd6, 1'b0);

        for (int k = 0; k < 8; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'b001) op = 3'b100;
            x = 3'($urandom_range(0, 7));
            y = 3'($urandom_range(0, 7));
            do_mvi(x, 16'($urandom_range(0, 65535)), 0);
            if (op >= 3'b110) do_mvi(y, 16'($urandom_range(0, 20)), 0);
            else              do_mvi(y, 16'($urandom_range(0, 65535)), 0);
            exec_instr(op, x, y, k[0]);
        end

        // Reset while waiting for an immediate, with run high on the same edge.
        dbg_sel = 3'd1;
        send_word(16'h0048);
        @(negedge clock);
        check("imm_state_ready", 32'(instr_ready), 32'd1);
        din   = 16'hABCD;
        run   = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 8; i++) m_rb[i] = 16'h0000;
        m_ovf = 1'b0;
        @(negedge clock);
        check("imm_rst_done", 32'(done), 32'd0);
        check("imm_rst_ready", 32'(instr_ready), 32'd1);
        check("imm_rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check("imm_rst_reg", 32'(dbg_data), 32'd0);
        end
        @(negedge clock);
        check("imm_rst_no_done", 32'(done), 32'd0);
        do_mvi(3'd1, 16'h1234, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
